// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// immediate/PC/writeback selects and the opcode-class decode helpers.
package multicycle_ctrl_fsm_pkg;

  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ALUR   = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd7
  } imm_sel_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MDR = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  typedef enum logic [3:0] {
    C_ALUI, C_ALUR, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_ILLEGAL
  } op_class_t;

  function automatic op_class_t decode_class(input logic [6:0] op);
    case (op)
      OP_ALUI:   return C_ALUI;
      OP_ALUR:   return C_ALUR;
      OP_LOAD:   return C_LOAD;
      OP_STORE:  return C_STORE;
      OP_BRANCH: return C_BRANCH;
      OP_JAL:    return C_JAL;
      OP_JALR:   return C_JALR;
      OP_LUI:    return C_LUI;
      default:   return C_ILLEGAL;
    endcase
  endfunction

  function automatic imm_sel_t imm_of(input op_class_t c);
    case (c)
      C_ALUI, C_LOAD, C_JALR: return IMM_I;
      C_STORE:                return IMM_S;
      C_BRANCH:               return IMM_B;
      C_LUI:                  return IMM_U;
      C_JAL:                  return IMM_J;
      default:                return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_timeout_ctr.sv
// Memory handshake watchdog: counts unanswered request cycles and flags the
// cycle on which the wait would reach TIMEOUT_CYCLES.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= cnt + CNT_W'(1);
  end

  // Fires on the TIMEOUT_CYCLES-th waiting cycle; a same-cycle mem_ready drops en.
  assign expired = en && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I-subset control sequencer (FETCH/DECODE/EXEC/MEM/WB) with a
// shared memory port and request watchdog. Define ILLEGAL_TRAP_EN to trap on illegal opcodes.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [2:0] imm_sel,
  output logic       alu_src_b,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       bus_err,
  output logic [2:0] state_o
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal_op
`endif
);

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_t    state, nxt;
  op_class_t cls_dec, cls_q, cls;
  logic      ctr_clr, ctr_en, ctr_expired;

  // DECODE sees the class straight from the IR; later states use the latched copy.
  assign cls_dec = decode_class(opcode);
  assign cls     = (state == S_DECODE) ? cls_dec : cls_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cls_q <= C_ILLEGAL;
    end else begin
      state <= nxt;
      if (state == S_DECODE) cls_q <= cls_dec;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        nxt = S_DECODE;
        else if (ctr_expired) nxt = S_ERR;
      end
      S_DECODE: begin
        if (cls_dec == C_ILLEGAL) nxt = TRAP_EN ? S_TRAP : S_FETCH;
        else                      nxt = S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          C_LOAD, C_STORE: nxt = S_MEM;
          C_BRANCH:        nxt = S_FETCH;
          default:         nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready)        nxt = (cls == C_STORE) ? S_FETCH : S_WB;
        else if (ctr_expired) nxt = S_ERR;
      end
      S_WB:     nxt = S_FETCH;
      default:  nxt = state;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    imm_sel   = IMM_NONE;
    alu_src_b = 1'b0;
    reg_write = 1'b0;
    wb_sel    = WB_ALU;
    retire    = 1'b0;
    bus_err   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_DECODE: begin
        imm_sel = imm_of(cls_dec);
        if (cls_dec == C_ILLEGAL && !TRAP_EN) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      S_EXEC: begin
        imm_sel   = imm_of(cls);
        alu_src_b = !(cls == C_ALUR || cls == C_BRANCH);
        if (cls == C_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
          retire   = 1'b1;
        end
      end
      S_MEM: begin
        imm_sel  = imm_of(cls);
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (cls == C_STORE);
        if (mem_ready) begin
          if (cls == C_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
          end else begin
            mdr_write = 1'b1;
          end
        end
      end
      S_WB: begin
        imm_sel   = imm_of(cls);
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        case (cls)
          C_LOAD: wb_sel = WB_MDR;
          C_LUI:  wb_sel = WB_IMM;
          C_JAL: begin
            wb_sel = WB_PC4;
            pc_src = PC_IMM;
          end
          C_JALR: begin
            wb_sel = WB_PC4;
            pc_src = PC_ALU;
          end
          default: wb_sel = WB_ALU;
        endcase
      end
      S_ERR:   bus_err = 1'b1;
      default: ;
    endcase
  end

  assign state_o = state;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = (state == S_TRAP);
`else
`endif

  // The watchdog restarts at every new request phase and whenever the bus answers.
  assign ctr_en  = mem_req && !mem_ready;
  assign ctr_clr = mem_ready || ((nxt == S_FETCH || nxt == S_MEM) && nxt != state);

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .expired(ctr_expired)
  );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm: per-cycle expected outputs come from an
// instruction-level model of the sequencer; TIMEOUT_CYCLES is shrunk to 4.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] ADDI = 7'b0010011, LW  = 7'b0000011, JALR = 7'b1100111;
  localparam logic [6:0] SW   = 7'b0100011, BEQ = 7'b1100011, LUI  = 7'b0110111;
  localparam logic [6:0] JAL  = 7'b1101111, ADD = 7'b0110011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_taken, mem_ready;
  logic       mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] imm_sel, state_o;
  logic       alu_src_b, reg_write, retire, bus_err;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_op;
`endif

  int total = 0;
  int bad = 0;
  int ret_cnt = 0;

  typedef struct packed {
    logic mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic alu_src_b, reg_write;
    logic [1:0] wb_sel;
    logic retire, bus_err;
    logic [2:0] state;
  } obs_t;

  multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_write(ir_write), .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src),
    .imm_sel(imm_sel), .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_sel(wb_sel),
    .retire(retire), .bus_err(bus_err), .state_o(state_o)
`ifdef ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      ADDI, LW, JALR: return 3'd0;
      SW:             return 3'd1;
      BEQ:            return 3'd2;
      LUI:            return 3'd3;
      JAL:            return 3'd4;
      default:        return 3'd7;
    endcase
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (exp_imm(op) != 3'd7) || (op == ADD);
  endfunction

  function automatic obs_t observe();
    obs_t a;
    a.mem_req = mem_req;     a.mem_we = mem_we;       a.addr_sel = addr_sel;
    a.ir_write = ir_write;   a.mdr_write = mdr_write; a.pc_write = pc_write;
    a.pc_src = pc_src;       a.imm_sel = imm_sel;     a.alu_src_b = alu_src_b;
    a.reg_write = reg_write; a.wb_sel = wb_sel;       a.retire = retire;
    a.bus_err = bus_err;     a.state = state_o;
    return a;
  endfunction

  function automatic obs_t mask_for(input obs_t e);
    obs_t m = '1;
    if (e.state != 3'd3) m.alu_src_b = 1'b0;
    if (e.state != 3'd5) m.wb_sel = 2'b00;
    if (!e.pc_write)     m.pc_src = 2'b00;
    if (!e.mem_req)      m.mem_we = 1'b0;
    return m;
  endfunction

  task automatic check(input string tag, input obs_t e, input obs_t m);
    obs_t a = observe();
    total++;
    assert ((((a ^ e) & m)) === '0)
    else begin
      bad++;
      $error("FAIL %s got=%05h exp=%05h mask=%05h", tag, a, e, m);
    end
  endtask

  task automatic step(input string tag, input logic rdy, input obs_t e);
    mem_ready = rdy;
    @(negedge clk);
    check(tag, e, mask_for(e));
    if (retire === 1'b1) ret_cnt++;
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t reset_obs();
    obs_t e = '0;
    e.imm_sel = 3'd7;
    return e;
  endfunction

  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("idle", 1'($urandom_range(0, 1)), reset_obs());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    #1 check("reset", reset_obs(), '1);
    release_reset();
  endtask

  // One instruction from the first FETCH cycle to its retire, waits given in cycles.
  task automatic run_instr(input logic [6:0] op, input logic bt, input int fd, input int md);
    obs_t e;
    int r0 = ret_cnt;
    bit ld = (op == LW), st = (op == SW), br = (op == BEQ);
    opcode = op;
    branch_taken = bt;
    for (int w = 0; w <= fd; w++) begin
      e = '0; e.state = 3'd1; e.imm_sel = 3'd7; e.mem_req = 1'b1; e.ir_write = (w == fd);
      step("fetch", w == fd, e);
    end
    e = '0; e.state = 3'd2; e.imm_sel = exp_imm(op);
    if (!is_legal(op)) begin
      e.pc_write = 1'b1; e.retire = 1'b1;
      step("decode_nop", 1'($urandom_range(0, 1)), e);
    end else begin
      step("decode", 1'($urandom_range(0, 1)), e);
      e = '0; e.state = 3'd3; e.imm_sel = exp_imm(op);
      e.alu_src_b = !(op == ADD || br);
      if (br) begin
        e.pc_write = 1'b1; e.pc_src = bt ? 2'd1 : 2'd0; e.retire = 1'b1;
      end
      step("exec", 1'($urandom_range(0, 1)), e);
      if (ld || st) begin
        for (int w = 0; w <= md; w++) begin
          e = '0; e.state = 3'd4; e.imm_sel = exp_imm(op);
          e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = st;
          if (w == md) begin
            e.mdr_write = ld; e.pc_write = st; e.retire = st;
          end
          step("mem", w == md, e);
        end
      end
      if (!br && !st) begin
        e = '0; e.state = 3'd5; e.imm_sel = exp_imm(op);
        e.reg_write = 1'b1; e.pc_write = 1'b1; e.retire = 1'b1;
        e.wb_sel = ld ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : (op == LUI) ? 2'd3 : 2'd0;
        e.pc_src = (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
        step("wb", 1'($urandom_range(0, 1)), e);
      end
    end
    total++;
    assert (ret_cnt - r0 == 1)
    else begin
      bad++;
      $error("FAIL retire_count op=%07b got=%0d exp=1", op, ret_cnt - r0);
    end
  endtask

  initial begin
    obs_t e;
    logic [6:0] legal [8];
    logic [6:0] op;
    legal = '{ADDI, LW, JALR, SW, BEQ, LUI, JAL, ADD};
    opcode = ADDI;
    branch_taken = 1'b0;
    do_reset();

    run_instr(ADDI, 1'b0, 0, 0);
    run_instr(LW,   1'b0, 0, 3);
    run_instr(SW,   1'b0, 0, 3);
    run_instr(BEQ,  1'b1, 0, 0);
    run_instr(BEQ,  1'b0, 0, 0);
    run_instr(JAL,  1'b0, 1, 0);
    run_instr(JALR, 1'b0, 0, 0);
    run_instr(LUI,  1'b0, 2, 0);
    run_instr(ADD,  1'b1, 0, 0);
    run_instr(LW,   1'b0, 3, 3);
`ifndef ILLEGAL_TRAP_EN
    run_instr(7'b1111111, 1'b0, 0, 0);
`endif

    for (int n = 0; n < 40; n++) begin
`ifdef ILLEGAL_TRAP_EN
      op = legal[$urandom_range(0, 7)];
`else
      if ($urandom_range(0, 9) < 8) begin
        op = legal[$urandom_range(0, 7)];
      end else begin
        op = 7'b1111111;
        for (int t = 0; t < 16; t++) begin
          op = 7'($urandom);
          if (!is_legal(op)) break;
        end
        if (is_legal(op)) op = 7'b1111111;
      end
`endif
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Watchdog: four unanswered FETCH cycles, then stuck in ERR.
    do_reset();
    opcode = ADDI;
    for (int w = 0; w < 4; w++) begin
      e = '0; e.state = 3'd1; e.imm_sel = 3'd7; e.mem_req = 1'b1;
      step("fetch_wait", 1'b0, e);
    end
    for (int k = 0; k < 3; k++) begin
      e = '0; e.state = 3'd6; e.imm_sel = 3'd7; e.bus_err = 1'b1;
      step("err", 1'($urandom_range(0, 1)), e);
    end

    // Reset arriving in the middle of a load's MEM phase.
    do_reset();
    opcode = LW;
    e = '0; e.state = 3'd1; e.imm_sel = 3'd7; e.mem_req = 1'b1; e.ir_write = 1'b1;
    step("fetch", 1'b1, e);
    e = '0; e.state = 3'd2; e.imm_sel = 3'd0;
    step("decode", 1'b0, e);
    e = '0; e.state = 3'd3; e.imm_sel = 3'd0; e.alu_src_b = 1'b1;
    step("exec", 1'b0, e);
    mem_ready = 1'b0;
    @(negedge clk);
    e = '0; e.state = 3'd4; e.imm_sel = 3'd0; e.mem_req = 1'b1; e.addr_sel = 1'b1;
    check("mem_before_rst", e, mask_for(e));
    #2 rst_n = 1'b0;
    #1 check("rst_mid_mem", reset_obs(), '1);
    release_reset();
    run_instr(SW, 1'b0, 1, 2);
    run_instr(ADDI, 1'b0, 0, 0);

`ifdef ILLEGAL_TRAP_EN
    opcode = 7'b1111111;
    e = '0; e.state = 3'd1; e.imm_sel = 3'd7; e.mem_req = 1'b1; e.ir_write = 1'b1;
    step("fetch", 1'b1, e);
    e = '0; e.state = 3'd2; e.imm_sel = 3'd7;
    step("decode_trap", 1'b0, e);
    for (int k = 0; k < 3; k++) begin
      e = '0; e.state = 3'd7;
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("trap", e, {mask_for(e)} & ~obs_t'({17'd0, 3'b000} | (20'h7 << 7)));
      total++;
      assert (illegal_op === 1'b1)
      else begin
        bad++;
        $error("FAIL illegal_op got=%b exp=1", illegal_op);
      end
      @(posedge clk);
      #1;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
